// File: rtl/reg_file_pkg.sv
// Shared definitions for the 2-read / 1-write register file.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and register count
//   clr_state_e                   : clear-sweep FSM states
//   cnt_width()                   : sweep counter width, one bit wider than the
//                                   address so the terminal count DEPTH fits
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int cnt_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/reg_file_clr_seq.sv
// Clear-sweep sequencer: after reset release, zeroes one register per cycle
// (address 0 upwards) and then reports the array as ready.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | sweep in progress (or held in reset); user writes are refused
// READY | all registers zeroed; user writes and reads are live
//
// Ports:
//   clk_i    : rising-edge clock
//   rst_n_i  : synchronous active-low reset
//   busy     : 1 while in CLEAR
//   clr_we   : sweep write strobe for this cycle
//   clr_addr : register being zeroed this cycle
module reg_file_clr_seq
    import reg_file_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int               CNT_W = cnt_width(ADDR_W);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(DEPTH);

    clr_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    // The write of address DEPTH-1 happens on this edge, so
                    // reaching TERM means the sweep has just completed.
                    if (cnt_d == TERM) begin
                        state_q <= READY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                READY: begin
                    busy_q <= 1'b0;
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    // No sweep write on a reset cycle: the counter is being restarted.
    assign clr_we   = busy_q & rst_n_i;
    assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with two registered read ports and one write port.
// After reset the array is zeroed by a DEPTH-cycle sweep; during the sweep
// the block is BUSY, read data is forced to 0 and user writes are dropped.
//
// Ports:
//   CLK     : rising-edge clock
//   RST_N   : synchronous active-low reset
//   SR1/SR2 : read addresses, data returned one cycle later
//   DR      : write address
//   LDREG   : write enable
//   DIN     : write data
//   SR1OUT  : registered read data, port 1
//   SR2OUT  : registered read data, port 2
//   BUSY    : clear sweep in progress
//   WR_DROP : one-cycle pulse after a refused write
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    input  logic [ADDR_W-1:0] DR,
    input  logic              LDREG,
    input  logic [WIDTH-1:0]  DIN,
    output logic [WIDTH-1:0]  SR1OUT,
    output logic [WIDTH-1:0]  SR2OUT,
    output logic              BUSY,
    output logic              WR_DROP
);

    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              usr_we;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [WIDTH-1:0]  wdata_d;
    logic [WIDTH-1:0]  sr1_d;
    logic [WIDTH-1:0]  sr2_d;
    logic [WIDTH-1:0]  sr1_q;
    logic [WIDTH-1:0]  sr2_q;
    logic              wr_drop_q;

    reg_file_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk_i    (CLK),
        .rst_n_i  (RST_N),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A user write is only honoured in READY and never on a reset cycle.
    assign usr_we = RST_N & ~busy & LDREG;

    always_comb begin
        we_d    = clr_we | usr_we;
        waddr_d = DR;
        wdata_d = DIN;
        if (clr_we) begin
            waddr_d = clr_addr;
            wdata_d = '0;
        end
    end

    // Storage has no reset; the sweep is what zeroes it.
    always_ff @(posedge CLK) begin
        if (we_d) begin
            mem_q[waddr_d] <= wdata_d;
        end
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    always_comb begin
        sr1_d = mem_q[SR1];
        sr2_d = mem_q[SR2];
        if (usr_we && (DR == SR1)) begin
            sr1_d = DIN;
        end
        if (usr_we && (DR == SR2)) begin
            sr2_d = DIN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sr1_q     <= '0;
            sr2_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= busy & LDREG;
            if (busy) begin
                sr1_q <= '0;
                sr2_q <= '0;
            end else begin
                sr1_q <= sr1_d;
                sr2_q <= sr2_d;
            end
        end
    end

    assign SR1OUT  = sr1_q;
    assign SR2OUT  = sr2_q;
    assign BUSY    = busy;
    assign WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default WIDTH=16, DEPTH=8
    logic        rst_n_a = 1'b0;
    logic [2:0]  sr1_a = '0, sr2_a = '0, dr_a = '0;
    logic        ld_a = 1'b0;
    logic [15:0] din_a = '0;
    logic [15:0] sr1out_a, sr2out_a;
    logic        busy_a, wr_drop_a;

    // Instance B: WIDTH=32, DEPTH=16
    logic        rst_n_b = 1'b0;
    logic [3:0]  sr1_b = '0, sr2_b = '0, dr_b = '0;
    logic        ld_b = 1'b0;
    logic [31:0] din_b = '0;
    logic [31:0] sr1out_b, sr2out_b;
    logic        busy_b, wr_drop_b;

    reg_file_2r1w u_dut_a (
        .CLK     (clk),
        .RST_N   (rst_n_a),
        .SR1     (sr1_a),
        .SR2     (sr2_a),
        .DR      (dr_a),
        .LDREG   (ld_a),
        .DIN     (din_a),
        .SR1OUT  (sr1out_a),
        .SR2OUT  (sr2out_a),
        .BUSY    (busy_a),
        .WR_DROP (wr_drop_a)
    );

    reg_file_2r1w #(.WIDTH(32), .DEPTH(16)) u_dut_b (
        .CLK     (clk),
        .RST_N   (rst_n_b),
        .SR1     (sr1_b),
        .SR2     (sr2_b),
        .DR      (dr_b),
        .LDREG   (ld_b),
        .DIN     (din_b),
        .SR1OUT  (sr1out_b),
        .SR2OUT  (sr2out_b),
        .BUSY    (busy_b),
        .WR_DROP (wr_drop_b)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [15:0] model [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One READY cycle on instance A with scoreboarded read results.
    task automatic cyc_a(input string tag, input logic ld, input logic [2:0] dr,
                         input logic [15:0] din, input logic [2:0] a1, input logic [2:0] a2);
        logic [15:0] e1, e2;
        ld_a = ld; dr_a = dr; din_a = din; sr1_a = a1; sr2_a = a2;
        e1 = (ld && dr == a1) ? din : model[a1];
        e2 = (ld && dr == a2) ? din : model[a2];
        q1.push_back({16'h0, e1});
        q2.push_back({16'h0, e2});
        if (ld) model[dr] = din;
        step();
        ld_a = 1'b0;
        chk({tag, "_sr1out"}, {16'h0, sr1out_a}, q1.pop_front());
        chk({tag, "_sr2out"}, {16'h0, sr2out_a}, q2.pop_front());
        chk({tag, "_wr_drop"}, {31'h0, wr_drop_a}, 32'h0);
    endtask

    // Runs instance A through its sweep, counting BUSY cycles; optionally
    // attempts a write at sweep cycle index drop_at.
    task automatic sweep_a(input int drop_at, output int n);
        int budget;
        bit dropped;
        n = 0;
        budget = 40;
        sr1_a = 3'd5; sr2_a = 3'd6;
        while (busy_a === 1'b1 && budget > 0) begin
            dropped = (n == drop_at);
            ld_a = dropped; dr_a = 3'd2; din_a = 16'hAAAA;
            step();
            ld_a = 1'b0;
            chk("sweep_wr_drop", {31'h0, wr_drop_a}, {31'h0, dropped});
            chk("sweep_sr1out", {16'h0, sr1out_a}, 32'h0);
            n++;
            budget--;
        end
        for (int i = 0; i < 8; i++) model[i] = '0;
    endtask

    initial begin
        int n;
        int budget;

        // Reset state: two cycles with RST_N low
        step();
        step();
        chk("rst_busy", {31'h0, busy_a}, 32'h1);
        chk("rst_wr_drop", {31'h0, wr_drop_a}, 32'h0);
        chk("rst_sr1out", {16'h0, sr1out_a}, 32'h0);
        chk("rst_sr2out", {16'h0, sr2out_a}, 32'h0);

        // Sweep with a refused write in the third sweep cycle
        rst_n_a = 1'b1;
        sweep_a(2, n);
        chk("sweep_len", n, 8);
        chk("ready_busy", {31'h0, busy_a}, 32'h0);

        // All registers read zero after the sweep
        for (int i = 0; i < 8; i++)
            cyc_a("clr_read", 1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i));

        // Write/read
        cyc_a("wr3", 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd1);
        cyc_a("rd3", 1'b0, 3'd0, 16'h0, 3'd3, 3'd4);

        // Forwarding to both ports, then to one port only
        cyc_a("wr5", 1'b1, 3'd5, 16'h1111, 3'd0, 3'd1);
        cyc_a("fwd55", 1'b1, 3'd5, 16'h2222, 3'd5, 3'd5);
        cyc_a("rd55", 1'b0, 3'd0, 16'h0, 3'd5, 3'd5);
        cyc_a("fwd6", 1'b1, 3'd6, 16'h3333, 3'd6, 3'd5);
        cyc_a("wr7", 1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd6);

        // Dropped write left R2 at zero; neighbours untouched
        cyc_a("rd2", 1'b0, 3'd0, 16'h0, 3'd2, 3'd3);
        cyc_a("rd_nb", 1'b0, 3'd0, 16'h0, 3'd4, 3'd7);

        // Reset in READY with a coincident write
        rst_n_a = 1'b0; ld_a = 1'b1; dr_a = 3'd1; din_a = 16'h5555;
        step();
        ld_a = 1'b0;
        chk("rst2_busy", {31'h0, busy_a}, 32'h1);
        chk("rst2_wr_drop", {31'h0, wr_drop_a}, 32'h0);
        chk("rst2_sr1out", {16'h0, sr1out_a}, 32'h0);

        // Reset mid-sweep during sweep cycle 5
        rst_n_a = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy", {31'h0, busy_a}, 32'h1);
        rst_n_a = 1'b0;
        step();
        rst_n_a = 1'b1;
        sweep_a(-1, n);
        chk("mid_sweep_len", n, 8);
        cyc_a("post_mid", 1'b0, 3'd0, 16'h0, 3'd1, 3'd7);

        // Scaling instance: WIDTH=32, DEPTH=16
        rst_n_b = 1'b1;
        n = 0;
        budget = 60;
        while (busy_b === 1'b1 && budget > 0) begin
            step();
            n++;
            budget--;
        end
        chk("b_sweep_len", n, 16);
        ld_b = 1'b1; dr_b = 4'd15; din_b = 32'hDEADBEEF;
        step();
        ld_b = 1'b1; dr_b = 4'd0; din_b = 32'h1;
        step();
        ld_b = 1'b0;
        sr1_b = 4'd15; sr2_b = 4'd0;
        q1.push_back(32'hDEADBEEF);
        q2.push_back(32'h1);
        step();
        chk("b_r15", sr1out_b, q1.pop_front());
        chk("b_r0", sr2out_b, q2.pop_front());
        sr1_b = 4'd8; sr2_b = 4'd14;
        q1.push_back(32'h0);
        q2.push_back(32'h0);
        step();
        chk("b_r8", sr1out_b, q1.pop_front());
        chk("b_r14", sr2out_b, q2.pop_front());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
